modmul_rr_scheduler: RTL
========================

# modmul_rr_scheduler

Round-robin scheduler that shares one pipelined modular multiplier (product followed by Barrett reduction) between two requesters. Each requester presents an operand pair through a valid/ready handshake. The block grants at most one request per cycle and tags it with the requester ID. It returns the fully reduced product (a·b) mod q on a single result port, with the ID attached. It sits between the NTT/polynomial-arithmetic engines and the shared reduction datapath of the HE accelerator.

## Interface
- q, default 65537: modulus; odd, q > 2.
- k, default $clog2(q): operand/result width (17 for the default).
- mu, default floor(2^(2k)/q): Barrett constant, k+1 bits; derived, never overridden independently.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_a, req0_b  in  k each  operands; caller guarantees each is < q.
- req0_ready  out  1  requester 0 accepted this cycle when valid & ready.
- req1_valid, req1_a, req1_b, req1_ready  same as above, for requester 1.
- res_valid  out  1  result present.
- res_id  out  1  requester that issued the result.
- res_data  out  k  (a·b) mod q, always < q.
- res_ready  in  1  consumer accepts the result when res_valid & res_ready.

## Operation
- Arbitration, round-robin with a 1-bit priority pointer `last`; reset value 1, so requester 0 wins first.
  - If only one requester is valid, it is granted.
  - If both are valid, the one ≠ `last` is granted.
  - `last` updates only on a grant.
- At most one reqN_ready is high per cycle.
  - reqN_ready = grant to N and no stall.
  - ready depends combinationally on valid; no combinational path exists from res_ready to reqN_ready except through the stall signal.
- Pipeline: 4 stages, each holding a valid bit, the ID, and data.
  - S1: registered a, b.
  - S2: x = a·b, 2k bits.
  - S3: t = ((x >> (k−1))·mu) >> (k+1); r = x − t·q, kept to k+2 bits (r < 3q).
  - S4: r reduced by up to two conditional subtractions of q; the result is < q.
- Output: S4 drives res_valid, res_id, res_data directly.
- Stall = res_valid & ~res_ready.
  - On stall, all stages hold and both readys go low.
  - Otherwise the pipeline advances every cycle; bubbles propagate as valid = 0.
- Operands ≥ q are out of contract and produce undefined res_data. Valid/ID sequencing must still be correct.
- Results emerge in grant order. There is no reordering and no drop.

## Timing
- Reset (async assert, sync deassert at the clock edge):
  - all stage valid bits = 0;
  - res_valid = 0, res_id = 0, res_data = 0;
  - req0_ready = req1_ready = 0 while reset is high;
  - `last` = 1.
- Latency: a grant at edge n produces res_valid high after edge n+4 (available in cycle n+4), provided no stall.
- Throughput: one result per cycle sustained when res_ready = 1.
- Stall for S cycles adds exactly S cycles to every in-flight item's latency. res_data and res_id stay stable while res_valid & ~res_ready.
- Simultaneous events:
  - A grant in the same cycle that the output retires is allowed.
  - A stall asserted in the same cycle as a valid request means no grant and `last` unchanged.
- Reset mid-operation discards all in-flight items. No result appears for them after reset release.
- res_valid is never asserted without a preceding grant.

## Test plan
- Reset, then req0 a=65536, b=65536 with res_ready=1 -> res_valid high exactly 4 cycles after the grant; res_id=0, res_data=1.
- Both requesters held valid for 6 cycles: req0 (12345, 2) and req1 (65536, 2) -> grants alternate 0,1,0,1,0,1; results alternate 24690 (id 0) and 65535 (id 1).
- res_ready low for 3 cycles while 4 items are in flight -> readys low, res_data and res_id frozen; after release, all 4 results arrive in order with no loss or duplication.
- Edge operands (0,x), (1,65536), (65536,65535) and 10k random pairs < q -> each res_data equals the (a·b) mod q reference model and is < q.
- Assert reset two cycles after 2 grants -> outputs return to reset values at once; no result for the flushed items; the first grant after release goes to req0.
- Only req1 valid, continuously -> req1 granted every cycle; `last` stays 1; results are 1/cycle.

Source files
------------

// File: rtl/modmul_rr_scheduler.sv
// modmul_rr_scheduler
// Two requesters share one 4-stage modular multiplier (product + Barrett
// reduction). A 1-bit round-robin pointer picks between them, every issued
// operation carries its requester ID, and results leave in grant order.
// A held result stalls the whole pipeline and blocks new grants.

module modmul_rr_scheduler #(
  parameter int unsigned Q = 65537,
  parameter int unsigned K = $clog2(Q)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [K-1:0] req0_a,
  input  logic [K-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [K-1:0] req1_a,
  input  logic [K-1:0] req1_b,
  output logic         req1_ready,
  output logic         res_valid,
  output logic         res_id,
  output logic [K-1:0] res_data,
  input  logic         res_ready
);

  // Barrett constant floor(2^(2k)/q), computed wide enough to hold 2^(2k).
  localparam int unsigned   W2      = 2 * K;
  localparam logic [W2:0]   POW2K   = (W2+1)'(1) << W2;
  localparam logic [W2:0]   MU_FULL = POW2K / (W2+1)'(Q);
  localparam logic [K:0]    MU      = (K+1)'(MU_FULL);
  localparam logic [K+1:0]  QW      = (K+2)'(Q);
  localparam logic [K+1:0]  Q2W     = (K+2)'(2 * Q);

  // Round-robin pointer: the requester that was granted most recently.
  logic last_q, last_d;

  // Stage 1: registered operands.
  logic         s1_v_q, s1_v_d, s1_id_q, s1_id_d;
  logic [K-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  // Stage 2: full-width product.
  logic          s2_v_q, s2_v_d, s2_id_q, s2_id_d;
  logic [W2-1:0] s2_x_q, s2_x_d;
  // Stage 3: Barrett remainder, still up to 3q - 1.
  logic         s3_v_q, s3_v_d, s3_id_q, s3_id_d;
  logic [K+1:0] s3_r_q, s3_r_d;
  // Stage 4: fully reduced result, drives the output port.
  logic         s4_v_q, s4_v_d, s4_id_q, s4_id_d;
  logic [K-1:0] s4_data_q, s4_data_d;

  logic            stall, grant0, grant1;
  logic [K:0]      xs;
  logic [W2+1:0]   prod;
  logic [K:0]      t;
  logic [K+1:0]    tq;
  logic [K+1:0]    red;

  // Arbitration, handshake and the next value of every pipeline stage.
  always_comb begin
    stall      = s4_v_q & ~res_ready;
    grant0     = req0_valid & (~req1_valid | last_q);
    grant1     = req1_valid & (~req0_valid | ~last_q);
    req0_ready = grant0 & ~stall & ~reset;
    req1_ready = grant1 & ~stall & ~reset;

    last_d = last_q;
    if (req0_ready) begin
      last_d = 1'b0;
    end else if (req1_ready) begin
      last_d = 1'b1;
    end

    s1_v_d  = req0_ready | req1_ready;
    s1_id_d = req1_ready;
    s1_a_d  = req1_ready ? req1_a : req0_a;
    s1_b_d  = req1_ready ? req1_b : req0_b;

    s2_v_d  = s1_v_q;
    s2_id_d = s1_id_q;
    s2_x_d  = {{K{1'b0}}, s1_a_q} * {{K{1'b0}}, s1_b_q};

    xs      = (K+1)'(s2_x_q >> (K - 1));
    prod    = {{(K+1){1'b0}}, xs} * {{(K+1){1'b0}}, MU};
    t       = (K+1)'(prod >> (K + 1));
    tq      = (K+2)'({1'b0, t} * QW);
    s3_v_d  = s2_v_q;
    s3_id_d = s2_id_q;
    s3_r_d  = (K+2)'(s2_x_q) - tq;

    if (s3_r_q >= Q2W) begin
      red = s3_r_q - Q2W;
    end else if (s3_r_q >= QW) begin
      red = s3_r_q - QW;
    end else begin
      red = s3_r_q;
    end
    s4_v_d    = s3_v_q;
    s4_id_d   = s3_id_q;
    s4_data_d = K'(red);
  end

  // Pointer and pipeline registers; every stage holds while the output is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q    <= 1'b1;
      s1_v_q    <= 1'b0;
      s1_id_q   <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s2_v_q    <= 1'b0;
      s2_id_q   <= 1'b0;
      s2_x_q    <= '0;
      s3_v_q    <= 1'b0;
      s3_id_q   <= 1'b0;
      s3_r_q    <= '0;
      s4_v_q    <= 1'b0;
      s4_id_q   <= 1'b0;
      s4_data_q <= '0;
    end else begin
      last_q <= last_d;
      if (!stall) begin
        s1_v_q    <= s1_v_d;
        s1_id_q   <= s1_id_d;
        s1_a_q    <= s1_a_d;
        s1_b_q    <= s1_b_d;
        s2_v_q    <= s2_v_d;
        s2_id_q   <= s2_id_d;
        s2_x_q    <= s2_x_d;
        s3_v_q    <= s3_v_d;
        s3_id_q   <= s3_id_d;
        s3_r_q    <= s3_r_d;
        s4_v_q    <= s4_v_d;
        s4_id_q   <= s4_id_d;
        s4_data_q <= s4_data_d;
      end
    end
  end

  assign res_valid = s4_v_q;
  assign res_id    = s4_id_q;
  assign res_data  = s4_data_q;

endmodule
